// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    ISSUE = 2'b10,
    HALT  = 2'b11
  } fetch_state_e;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_BRANCH = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Instruction field bit positions (MIPS R/I/J formats).
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int SA_HI   = 10;
  localparam int SA_LO   = 6;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;
  localparam int TGT_HI  = 25;
  localparam int TGT_LO  = 0;

endpackage

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC selection: sequential, PC-relative branch, or region jump.
module next_pc_logic
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] imm_ext,
  input  logic [25:0] target26,
  output logic [31:0] pc_plus4,
  output logic [31:0] next_pc
);

  logic signed [31:0] br_off;
  logic        [31:0] br_target;
  logic        [31:0] jmp_target;

  assign pc_plus4   = pc + 32'd4;
  // Word offset scaled to bytes; the top two bits of imm_ext fall off, modulo 2^32.
  assign br_off     = signed'(imm_ext) <<< 2;
  assign br_target  = pc_plus4 + unsigned'(br_off);
  assign jmp_target = {pc_plus4[31:28], target26, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    case (PCSrc)
      PCSRC_BRANCH: next_pc = br_target;
      PCSRC_JUMP:   next_pc = jmp_target;
      default:      next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches via req/ack, holds the instruction register.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] imm_ext,
  input  logic        step,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  sa,
  output logic [5:0]  func,
  output logic [15:0] imm16,
  output logic [25:0] target26,
  output logic        instr_valid,
  output logic        halted
);

  // Low bits forced clear so a misaligned parameter cannot leak into pc[1:0].
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         req_q, req_d;
  logic         valid_q, valid_d;
  logic         halted_q, halted_d;
  logic [31:0]  next_pc;

  next_pc_logic u_next_pc (
    .pc       (pc_q),
    .PCSrc    (PCSrc),
    .imm_ext  (imm_ext),
    .target26 (instr_q[TGT_HI:TGT_LO]),
    .pc_plus4 (pc_plus4),
    .next_pc  (next_pc)
  );

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC_ALIGNED;
      instr_q  <= 32'd0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    req_d    = req_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end
      FETCH: begin
        // A coincident step is dropped: the instruction has not been issued yet.
        if (imem_ack) begin
          instr_d = imem_rdata;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (step) begin
          valid_d = 1'b0;
          if (PCWre) begin
            pc_d    = next_pc;
            req_d   = 1'b1;
            state_d = FETCH;
          end else begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
        end
      end
      HALT: begin
        req_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;

  assign op       = instr_q[OP_HI:OP_LO];
  assign rs       = instr_q[RS_HI:RS_LO];
  assign rt       = instr_q[RT_HI:RT_LO];
  assign rd       = instr_q[RD_HI:RD_LO];
  assign sa       = instr_q[SA_HI:SA_LO];
  assign func     = instr_q[FUNC_HI:FUNC_LO];
  assign imm16    = instr_q[IMM_HI:IMM_LO];
  assign target26 = instr_q[TGT_HI:TGT_LO];

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against an arithmetic next-PC reference model.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        PCWre = 1'b0;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] imm_ext = 32'd0;
  logic        step = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_ack = 1'b0;
  logic [31:0] pc, pc_plus4, instr;
  logic [5:0]  op, func;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm16;
  logic [25:0] target26;
  logic        instr_valid, halted;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .imm_ext(imm_ext),
    .step(step), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .pc_plus4(pc_plus4),
    .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .func(func),
    .imm16(imm16), .target26(target26), .instr_valid(instr_valid), .halted(halted)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
  endtask

  // Reference next PC from the architectural rules.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [1:0] src,
                                           input logic [31:0] imm, input logic [31:0] ins);
    logic [31:0] seq;
    seq = cur + 32'd4;
    case (src)
      2'b01:   return seq + imm * 32'd4;
      2'b10:   return {seq[31:28], ins[25:0], 2'b00};
      default: return seq;
    endcase
  endfunction

  task automatic chk_fields();
    chk("instr", instr, m_instr);
    chk("op", 32'(op), 32'(m_instr[31:26]));
    chk("rs", 32'(rs), 32'(m_instr[25:21]));
    chk("rt", 32'(rt), 32'(m_instr[20:16]));
    chk("rd", 32'(rd), 32'(m_instr[15:11]));
    chk("sa", 32'(sa), 32'(m_instr[10:6]));
    chk("func", 32'(func), 32'(m_instr[5:0]));
    chk("imm16", 32'(imm16), 32'(m_instr[15:0]));
    chk("target26", 32'(target26), 32'(m_instr[25:0]));
  endtask

  // Serve one outstanding request after wait_n idle cycles; noise adds ignored steps.
  task automatic do_fetch(input logic [31:0] data, input int wait_n, input bit noise);
    chk("req_up", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("pc_plus4", pc_plus4, m_pc + 32'd4);
    for (int i = 0; i < wait_n; i++) begin
      step  = noise ? 1'($urandom) : 1'b0;
      PCWre = 1'($urandom);
      PCSrc = 2'($urandom);
      tick();
      chk("wait_req", 32'(imem_req), 32'd1);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      chk("wait_pc", pc, m_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    step       = noise ? 1'($urandom) : 1'b0;
    tick();
    imem_ack   = 1'b0;
    step       = 1'b0;
    imem_rdata = $urandom;
    m_instr    = data;
    chk("ack_valid", 32'(instr_valid), 32'd1);
    chk("ack_req", 32'(imem_req), 32'd0);
    chk("ack_pc", pc, m_pc);
    chk_fields();
  endtask

  // Retire the current instruction; noise adds an ignored ack and stepless cycle first.
  task automatic do_step(input logic [1:0] src, input logic [31:0] imm, input bit wre,
                         input bit noise);
    if (noise) begin
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      PCWre      = 1'($urandom);
      PCSrc      = 2'($urandom);
      imm_ext    = $urandom;
      tick();
      imem_ack = 1'b0;
      chk("iss_hold_instr", instr, m_instr);
      chk("iss_hold_valid", 32'(instr_valid), 32'd1);
      chk("iss_hold_pc", pc, m_pc);
      chk("iss_hold_req", 32'(imem_req), 32'd0);
    end
    step    = 1'b1;
    PCSrc   = src;
    imm_ext = imm;
    PCWre   = wre;
    tick();
    step  = 1'b0;
    PCWre = 1'b0;
    if (wre) begin
      m_pc = ref_next(m_pc, src, imm, m_instr);
      chk("step_pc", pc, m_pc);
      chk("step_req", 32'(imem_req), 32'd1);
      chk("step_addr", imem_addr, m_pc);
      chk("step_valid", 32'(instr_valid), 32'd0);
      chk("step_halted", 32'(halted), 32'd0);
    end else begin
      chk("halt_pc", pc, m_pc);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_req", 32'(imem_req), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rimm;
    Reset = 1'b1;
    tick();
    tick();
    m_pc = 32'd0;
    m_instr = 32'd0;
    chk("rst_pc", pc, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    Reset = 1'b0;
    tick();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'd0);
    do_fetch(32'h0222_4020, 3, 1'b0);
    chk("d_op", 32'(op), 32'd0);
    chk("d_rs", 32'(rs), 32'd17);
    chk("d_rt", 32'(rt), 32'd2);
    chk("d_rd", 32'(rd), 32'd8);
    chk("d_func", 32'(func), 32'h20);

    do_step(2'b00, 32'd0, 1'b1, 1'b0);
    chk("d_seq_pc", pc, 32'd4);
    do_fetch($urandom, 0, 1'b0);
    do_step(2'b00, 32'd0, 1'b1, 1'b0);
    do_fetch($urandom, 1, 1'b1);
    do_step(2'b01, 32'hFFFF_FFFE, 1'b1, 1'b0);
    chk("d_branch_back", pc, 32'd4);
    do_fetch($urandom, 2, 1'b1);
    do_step(2'b01, 32'd2, 1'b1, 1'b1);
    chk("d_branch_fwd", pc, 32'h10);
    do_fetch(32'h0800_0010, 1, 1'b0);
    do_step(2'b10, $urandom, 1'b1, 1'b0);
    chk("d_jump", pc, 32'h40);
    do_fetch($urandom, 0, 1'b0);
    do_step(2'b01, 32'h3FFF_FFEE, 1'b1, 1'b0);
    chk("d_to_top", pc, 32'hFFFF_FFFC);
    do_fetch($urandom, 2, 1'b0);
    do_step(2'b00, $urandom, 1'b1, 1'b0);
    chk("d_wrap", pc, 32'd0);
    do_fetch($urandom, 0, 1'b0);
    do_step(2'b01, 32'h3F, 1'b1, 1'b0);
    do_fetch($urandom, 1, 1'b0);
    do_step(2'b11, $urandom, 1'b1, 1'b1);
    chk("d_reserved", pc, 32'h104);

    for (int n = 0; n < 40; n++) begin
      do_fetch($urandom, int'($urandom_range(0, 4)), 1'($urandom));
      rimm = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) rimm = -rimm;
      do_step(2'($urandom_range(0, 3)), rimm, 1'b1, 1'($urandom));
    end

    // Reset while a request is outstanding; the late ack must be dropped.
    chk("mid_req", 32'(imem_req), 32'd1);
    Reset = 1'b1;
    tick();
    Reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    m_pc    = 32'd0;
    m_instr = 32'd0;
    chk("mid_rst_req", 32'(imem_req), 32'd0);
    chk("mid_rst_pc", pc, 32'd0);
    chk("mid_rst_instr", instr, 32'd0);
    tick();
    imem_ack = 1'b0;
    chk("mid_late_instr", instr, 32'd0);
    chk("mid_late_valid", 32'(instr_valid), 32'd0);
    chk("mid_new_req", 32'(imem_req), 32'd1);
    do_fetch($urandom, 1, 1'b0);
    do_step(2'b01, 32'd7, 1'b1, 1'b0);
    chk("d_pc20", pc, 32'h20);
    do_fetch($urandom, 2, 1'b1);
    do_step(2'($urandom), $urandom, 1'b0, 1'b1);

    for (int i = 0; i < 20; i++) begin
      imem_ack   = 1'($urandom);
      imem_rdata = $urandom;
      step       = 1'($urandom);
      PCWre      = 1'b1;
      PCSrc      = 2'($urandom);
      tick();
      chk("hold_req", 32'(imem_req), 32'd0);
      chk("hold_halted", 32'(halted), 32'd1);
      chk("hold_pc", pc, 32'h20);
      chk("hold_instr", instr, m_instr);
    end
    imem_ack = 1'b0;
    step     = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
